// File: rtl/channel_decoder_coef_arb.sv
// channel_decoder_coef_arb
// Shares the single-port coefficient ROM between two FIR/MAC requesters.
// A granted requester's burst (base, tap count) is walked through the ROM
// with circular wrap at MEM_SIZE. The coefficients come back on a tagged
// stream (out_id, out_last).
//
// Build option:
//   COEF_ARB_PRIORITY_EN - when defined, requester 0 always wins a tie.
//                          When undefined, ties are resolved round robin
//                          using last_grant. Timing is the same either way.
//
// State table:
//   state   | meaning
//   S_IDLE  | no ROM reads; a valid request is granted and its burst latched
//   S_BURST | one ROM read per cycle until the remaining count is exhausted

module channel_decoder_coef_arb #(
  parameter int DWIDTH   = 16,
  parameter int AWIDTH   = 7,
  parameter int MEM_SIZE = 73
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              req0_valid,
  input  logic [AWIDTH-1:0] req0_base,
  input  logic [AWIDTH-1:0] req0_len,
  output logic              req0_ready,

  input  logic              req1_valid,
  input  logic [AWIDTH-1:0] req1_base,
  input  logic [AWIDTH-1:0] req1_len,
  output logic              req1_ready,

  output logic [AWIDTH-1:0] rom_address0,
  output logic              rom_ce0,
  input  logic [DWIDTH-1:0] rom_q0,

  output logic [DWIDTH-1:0] out_data,
  output logic              out_valid,
  output logic              out_last,
  output logic              out_id,
  output logic              busy
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  localparam logic [AWIDTH-1:0] MEM_SZ    = AWIDTH'(MEM_SIZE);
  localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(MEM_SIZE - 1);
  localparam logic [AWIDTH-1:0] ONE       = AWIDTH'(1);

  state_t            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [AWIDTH-1:0] remain_q, remain_d;
  logic              id_q, id_d;

  // Tag pipeline: lines the issue/last/id of each read up with rom_q0.
  logic              issue_q, issue_d;
  logic              tag_last_q, tag_last_d;
  logic              tag_id_q, tag_id_d;

  logic              grant_any;
  logic              grant_id;
  logic [AWIDTH-1:0] sel_base;
  logic [AWIDTH-1:0] sel_len;
  logic [AWIDTH-1:0] base_mod;
  logic [AWIDTH-1:0] addr_inc;
  logic              burst_issue;
  logic              burst_last;

  // Choose the winning requester: a lone valid wins, a tie uses the build option.
  always_comb begin
    grant_any = (req0_valid | req1_valid) & ~reset;
    grant_id  = 1'b0;
    if (req0_valid && req1_valid) begin
`ifdef COEF_ARB_PRIORITY_EN
      grant_id = 1'b0;
`else
      grant_id = ~last_grant_q;
`endif
    end else if (req1_valid) begin
      grant_id = 1'b1;
    end
  end

  // Select the winner's burst, fold an out-of-range base back into the table,
  // and compute the wrapped successor of the current address.
  always_comb begin
    sel_base = grant_id ? req1_base : req0_base;
    sel_len  = grant_id ? req1_len  : req0_len;
    // One subtraction is enough: the base port cannot reach 2*MEM_SIZE.
    base_mod = (sel_base >= MEM_SZ) ? (sel_base - MEM_SZ) : sel_base;
    addr_inc = (addr_q == LAST_ADDR) ? '0 : (addr_q + ONE);
  end

  // FSM next state, burst bookkeeping and the ready pulses.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    remain_d     = remain_q;
    id_d         = id_q;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    burst_issue  = 1'b0;
    burst_last   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (grant_any) begin
          req0_ready   = ~grant_id;
          req1_ready   = grant_id;
          last_grant_d = grant_id;
          id_d         = grant_id;
          // A zero-length burst is accepted but issues nothing, and the
          // ROM address is left where it was.
          if (sel_len != '0) begin
            addr_d   = base_mod;
            remain_d = sel_len;
            state_d  = S_BURST;
          end
        end
      end

      S_BURST: begin
        burst_issue = 1'b1;
        burst_last  = (remain_q == ONE);
        remain_d    = remain_q - ONE;
        if (burst_last) begin
          // The final address stays on the port while idle.
          state_d = S_IDLE;
        end else begin
          addr_d = addr_inc;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Tag for the read issued this cycle, consumed one cycle later with rom_q0.
  always_comb begin
    issue_d    = burst_issue;
    tag_last_d = burst_last;
    tag_id_d   = id_q;
  end

  // Control registers; last_grant resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      addr_q       <= '0;
      remain_q     <= '0;
      id_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      remain_q     <= remain_d;
      id_q         <= id_d;
    end
  end

  // Tag pipeline registers; a reset drops any in-flight beat, including its last flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      issue_q    <= 1'b0;
      tag_last_q <= 1'b0;
      tag_id_q   <= 1'b0;
    end else begin
      issue_q    <= issue_d;
      tag_last_q <= tag_last_d;
      tag_id_q   <= tag_id_d;
    end
  end

  // Drive the ROM port, the output stream and the busy flag.
  always_comb begin
    rom_ce0      = burst_issue;
    rom_address0 = addr_q;
    out_data     = rom_q0;
    out_valid    = issue_q;
    out_last     = tag_last_q;
    out_id       = tag_id_q;
    busy         = (state_q == S_BURST) | issue_q;
  end

endmodule

// File: tb/tb_channel_decoder_coef_arb.sv
// Bench for channel_decoder_coef_arb: a behavioural ROM plus a scoreboard of
// expected coefficient beats, pushed at grant time and popped by a monitor.
module tb_channel_decoder_coef_arb;

  localparam int DW = 16;
  localparam int AW = 7;
  localparam int MS = 73;

  logic          clk;
  logic          reset;
  logic          req0_valid, req1_valid;
  logic [AW-1:0] req0_base, req0_len, req1_base, req1_len;
  logic          req0_ready, req1_ready;
  logic [AW-1:0] rom_address0;
  logic          rom_ce0;
  logic [DW-1:0] rom_q0;
  logic [DW-1:0] out_data;
  logic          out_valid, out_last, out_id, busy;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          last;
    logic          id;
  } beat_t;

  beat_t         sb[$];
  logic [DW-1:0] mem [0:MS-1];
  int            vectors;
  int            miscompares;

  channel_decoder_coef_arb #(.DWIDTH(DW), .AWIDTH(AW), .MEM_SIZE(MS)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_base(req0_base), .req0_len(req0_len), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_base(req1_base), .req1_len(req1_len), .req1_ready(req1_ready),
    .rom_address0(rom_address0), .rom_ce0(rom_ce0), .rom_q0(rom_q0),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_id(out_id), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM model: 1-cycle latency, output register only loads when ce is high.
  always @(posedge clk) begin
    if (rom_ce0) rom_q0 <= (int'(rom_address0) < MS) ? mem[rom_address0] : 'x;
  end

  // Scoreboard monitor: every output beat must match the oldest expected beat.
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL beat_unexpected: got data=%h last=%b id=%b, required no beat", out_data, out_last, out_id);
      end else begin
        beat_t e;
        e = sb.pop_front();
        if ({out_data, out_last, out_id} !== e) begin
          miscompares++;
          $display("FAIL beat: got data=%h last=%b id=%b, required data=%h last=%b id=%b",
                   out_data, out_last, out_id, e.d, e.last, e.id);
        end
      end
    end
  end

  task automatic push_burst(input logic id, input int base, input int len, input int count);
    int b;
    beat_t e;
    b = base % MS;
    for (int k = 0; k < count; k++) begin
      e.d    = mem[(b + k) % MS];
      e.last = (k == len - 1);
      e.id   = id;
      sb.push_back(e);
    end
  endtask

  task automatic drive_req(input logic id, input logic v, input int base, input int len);
    logic [AW-1:0] b7, l7;
    b7 = base[AW-1:0];
    l7 = len[AW-1:0];
    if (id) begin req1_valid = v; req1_base = b7; req1_len = l7; end
    else    begin req0_valid = v; req0_base = b7; req0_len = l7; end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req0_valid = 1'b1; req0_base = '0; req0_len = 7'd3;
    @(negedge clk); #1;
    vectors++;
    if ({req0_ready, req1_ready, rom_ce0, out_valid, out_last, out_id, busy} !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b, required 0000000",
               {req0_ready, req1_ready, rom_ce0, out_valid, out_last, out_id, busy});
    end
    vectors++;
    if (rom_address0 !== '0) begin
      miscompares++;
      $display("FAIL reset_address: got %0d, required 0", rom_address0);
    end
    req0_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk); #1;
    vectors++;
    if ({rom_ce0, busy, out_valid} !== 3'b0) begin
      miscompares++;
      $display("FAIL idle_after_reset: got ce/busy/valid=%b, required 000", {rom_ce0, busy, out_valid});
    end
  endtask

  // Single requester burst: ready at G, addresses G+1..G+len, beats G+2..G+len+1.
  task automatic test_burst(input logic id, input int base, input int len);
    int b;
    logic exp_ce;
    b = base % MS;
    @(negedge clk);
    drive_req(id, 1'b1, base, len);
    #1;
    vectors++;
    if ({req1_ready, req0_ready} !== (id ? 2'b10 : 2'b01)) begin
      miscompares++;
      $display("FAIL burst_grant: got ready1/ready0=%b, required id %0d", {req1_ready, req0_ready}, id);
    end
    push_burst(id, base, len, len);
    for (int c = 1; c <= len + 2; c++) begin
      @(negedge clk);
      if (c == 1) drive_req(id, 1'b0, base, len);
      #1;
      if (c == 1) begin
        vectors++;
        if (req0_ready || req1_ready) begin
          miscompares++;
          $display("FAIL ready_pulse_width: got ready high at G+1, required low");
        end
      end
      exp_ce = (c <= len);
      vectors++;
      if (rom_ce0 !== exp_ce) begin
        miscompares++;
        $display("FAIL rom_ce0 G+%0d: got %b, required %b", c, rom_ce0, exp_ce);
      end
      if (exp_ce) begin
        vectors++;
        if (int'(rom_address0) !== (b + c - 1) % MS) begin
          miscompares++;
          $display("FAIL rom_address0 G+%0d: got %0d, required %0d", c, rom_address0, (b + c - 1) % MS);
        end
      end
      vectors++;
      if (busy !== (c <= len + 1)) begin
        miscompares++;
        $display("FAIL busy G+%0d: got %b, required %b", c, busy, (c <= len + 1));
      end
    end
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL burst_drain: got %0d beats outstanding, required 0", sb.size());
    end
  endtask

  task automatic test_len_zero();
    logic [AW-1:0] addr_before;
    @(negedge clk);
    drive_req(1'b0, 1'b1, 5, 0);
    #1;
    addr_before = rom_address0;
    vectors++;
    if ({req1_ready, req0_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL len0_grant: got ready1/ready0=%b, required 01", {req1_ready, req0_ready});
    end
    @(negedge clk);
    drive_req(1'b0, 1'b0, 5, 0);
    drive_req(1'b1, 1'b1, 30, 1);
    #1;
    vectors++;
    if ({rom_ce0, out_valid, busy} !== 3'b0 || rom_address0 !== addr_before) begin
      miscompares++;
      $display("FAIL len0_no_issue: got ce/valid/busy=%b addr=%0d, required 000 addr=%0d",
               {rom_ce0, out_valid, busy}, rom_address0, addr_before);
    end
    vectors++;
    if ({req1_ready, req0_ready} !== 2'b10) begin
      miscompares++;
      $display("FAIL len0_next_grant: got ready1/ready0=%b, required 10", {req1_ready, req0_ready});
    end
    push_burst(1'b1, 30, 1, 1);
    @(negedge clk);
    drive_req(1'b1, 1'b0, 30, 1);
    #1;
    vectors++;
    if (rom_ce0 !== 1'b1 || rom_address0 !== 7'd30) begin
      miscompares++;
      $display("FAIL len0_follow_addr: got ce=%b addr=%0d, required ce=1 addr=30", rom_ce0, rom_address0);
    end
    repeat (3) @(negedge clk);
    #1;
    vectors++;
    if (sb.size() != 0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL len0_drain: got %0d outstanding busy=%b, required 0 busy=0", sb.size(), busy);
    end
  endtask

  task automatic test_tie();
    int grants, last_g, base_w;
    logic w, exp_w;
    grants = 0;
    last_g = 0;
    exp_w  = 1'b0;
    @(negedge clk);
    drive_req(1'b0, 1'b1, 10, 2);
    drive_req(1'b1, 1'b1, 20, 2);
    for (int cyc = 0; cyc < 40 && grants < 4; cyc++) begin
      if (cyc > 0) @(negedge clk);
      #1;
      if (req0_ready || req1_ready) begin
        w = req1_ready;
        vectors++;
        if (req0_ready && req1_ready) begin
          miscompares++;
          $display("FAIL tie_double_grant: got both ready, required one");
        end
        vectors++;
        if (w !== exp_w) begin
          miscompares++;
          $display("FAIL tie_winner %0d: got %0d, required %0d", grants, w, exp_w);
        end
        if (grants > 0) begin
          vectors++;
          if (cyc - last_g != 3) begin
            miscompares++;
            $display("FAIL tie_spacing: got %0d cycles, required 3", cyc - last_g);
          end
        end
        base_w = w ? 20 : 10;
        push_burst(w, base_w, 2, 2);
        last_g = cyc;
        grants++;
`ifdef COEF_ARB_PRIORITY_EN
        exp_w = 1'b0;
`else
        exp_w = ~exp_w;
`endif
      end
    end
    vectors++;
    if (grants != 4) begin
      miscompares++;
      $display("FAIL tie_timeout: got %0d grants, required 4", grants);
    end
    @(negedge clk);
    drive_req(1'b0, 1'b0, 10, 2);
    drive_req(1'b1, 1'b0, 20, 2);
    repeat (4) @(negedge clk);
    #1;
    vectors++;
    if (sb.size() != 0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL tie_drain: got %0d outstanding busy=%b, required 0 busy=0", sb.size(), busy);
    end
  endtask

  task automatic test_reset_mid_burst();
    @(negedge clk);
    drive_req(1'b0, 1'b1, 40, 10);
    #1;
    vectors++;
    if (req0_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst_grant: got %b, required 1", req0_ready);
    end
    push_burst(1'b0, 40, 10, 2);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (c == 1) drive_req(1'b0, 1'b0, 40, 10);
      #1;
      vectors++;
      if (rom_ce0 !== 1'b1 || int'(rom_address0) !== 39 + c) begin
        miscompares++;
        $display("FAIL midrst_addr G+%0d: got ce=%b addr=%0d, required ce=1 addr=%0d",
                 c, rom_ce0, rom_address0, 39 + c);
      end
    end
    #1;
    reset = 1'b1;
    #1;
    vectors++;
    if ({out_valid, rom_ce0, busy, out_last} !== 4'b0) begin
      miscompares++;
      $display("FAIL midrst_async_clear: got valid/ce/busy/last=%b, required 0000",
               {out_valid, rom_ce0, busy, out_last});
    end
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL midrst_beats: got %0d outstanding, required 0", sb.size());
      sb.delete();
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk); #1;
    vectors++;
    if ({out_valid, rom_ce0, busy} !== 3'b0 || rom_address0 !== '0) begin
      miscompares++;
      $display("FAIL midrst_idle: got valid/ce/busy=%b addr=%0d, required 000 addr=0",
               {out_valid, rom_ce0, busy}, rom_address0);
    end
    test_burst(1'b0, 40, 1);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    for (int i = 0; i < MS; i++) mem[i] = DW'(i * 977 + 16'h3C5A);
    req0_valid = 1'b0; req0_base = '0; req0_len = '0;
    req1_valid = 1'b0; req1_base = '0; req1_len = '0;

    test_reset();
    test_burst(1'b0, 0, 4);
    test_burst(1'b1, 71, 4);
    test_burst(1'b1, 80, 3);
    test_len_zero();
    test_tie();
    test_reset_mid_burst();
    test_burst(1'b0, 0, 73);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
